// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PFX_ID    = 2'd1,
    PFX_COLON = 2'd2,
    SEND      = 2'd3
  } arb_state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam int         MAX_CLIENTS = 10;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client-side and UART-side handshake bundle for uart_tx_arbiter.
// master = the arbiter, slave = clients plus the uart_tx serialiser.
interface uart_tx_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int ID_W      = 2
);
  logic [N_CLIENTS-1:0]   cl_req;
  logic [8*N_CLIENTS-1:0] cl_data;
  logic [N_CLIENTS-1:0]   cl_last;
  logic [N_CLIENTS-1:0]   cl_ack;
  logic                   uart_req;
  logic [7:0]             uart_data;
  logic                   uart_ready;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;

  modport master (
    input  cl_req, cl_data, cl_last, uart_ready,
    output cl_ack, uart_req, uart_data, grant_id, busy
  );

  modport slave (
    output cl_req, cl_data, cl_last, uart_ready,
    input  cl_ack, uart_req, uart_data, grant_id, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request strictly
// after ptr_i, wrapping circularly, so ptr_i itself has lowest priority.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the nearest requester is assigned last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int off = N; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr_i) + off) % N);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx among N_CLIENTS sources.
// Define UART_ARB_PREFIX_EN to emit "<id>:" before every packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int ID_W      = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_tx_arbiter_if.master  bus
);

  arb_state_e      state_q;
  logic [ID_W-1:0] grant_id_q;
  logic [ID_W-1:0] rr_ptr_q;

  logic            pick_valid;
  logic [ID_W-1:0] pick_idx;
  logic            gnt_req;
  logic            gnt_last;
  logic [7:0]      gnt_data;
  logic            accept;

  rr_pick #(
    .N     (N_CLIENTS),
    .IDX_W (ID_W)
  ) u_pick (
    .req_i   (bus.cl_req),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign gnt_req  = bus.cl_req[grant_id_q];
  assign gnt_last = bus.cl_last[grant_id_q];
  assign gnt_data = bus.cl_data[{grant_id_q, 3'b000} +: 8];
  // A ready pulse only counts while the granted client is actually offering a byte.
  assign accept   = (state_q == SEND) && gnt_req && bus.uart_ready;

  always_comb begin
    bus.uart_req  = 1'b0;
    bus.uart_data = 8'h00;
    bus.cl_ack    = '0;
    case (state_q)
      SEND: begin
        bus.uart_req           = gnt_req;
        bus.uart_data          = gnt_data;
        bus.cl_ack[grant_id_q] = accept;
      end
`ifdef UART_ARB_PREFIX_EN
      PFX_ID: begin
        bus.uart_req  = 1'b1;
        bus.uart_data = 8'(ASCII_ZERO + 8'(grant_id_q));
      end
      PFX_COLON: begin
        bus.uart_req  = 1'b1;
        bus.uart_data = ASCII_COLON;
      end
`endif
      default: ;
    endcase
  end

  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(N_CLIENTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_id_q <= pick_idx;
`ifdef UART_ARB_PREFIX_EN
            state_q    <= PFX_ID;
`else
            state_q    <= SEND;
`endif
          end
        end
`ifdef UART_ARB_PREFIX_EN
        PFX_ID:    if (bus.uart_ready) state_q <= PFX_COLON;
        PFX_COLON: if (bus.uart_ready) state_q <= SEND;
`endif
        SEND: begin
          if (accept && gnt_last) begin
            rr_ptr_q <= grant_id_q;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
